puon_rst_seq: RTL and testbench



---
 rtl/puon_rst_seq.sv | 125 ++++++++++++
 tb/tb_puon_rst_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/puon_rst_seq.sv
// Power-on / CPU reset sequencer: POR -> HOLD -> RUN, with watchdog and
// software reset pulses (SRST) that re-run the CPU-hold phase in place.
module puon_rst_seq #(
  parameter int PUON_CYCLES  = 16,
  parameter int CPURS_CYCLES = 8,
  parameter int SRST_CYCLES  = 4,
  parameter int CE_DIV       = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       RESB,
  input  logic       WDT_RST,
  input  logic       SRST_REQ,
  output logic       SRST_ACK,
  output logic       PUONOUT,
  output logic       CPURSOUTB,
  output logic       CE0,
  output logic       CLK30MHz,
  output logic [1:0] seq_state,
  output logic [1:0] rst_cause
);

  typedef enum logic [1:0] {
    ST_POR  = 2'b00,
    ST_HOLD = 2'b01,
    ST_RUN  = 2'b10,
    ST_SRST = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Terminal counts: the phase ends on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] PUON_LAST  = CNT_W'(PUON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPURS_LAST = CNT_W'(CPURS_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_LAST  = CNT_W'(SRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CE_LAST    = CNT_W'(CE_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign seq_state = state;

  // SRST_REQ/SRST_ACK is a 4-phase handshake: a request is taken only in RUN
  // with ACK low; ACK then stays high until REQ is sampled low, and clears on
  // that edge regardless of state. A request blocked by a watchdog stays
  // pending because the requester keeps REQ high.
  always_ff @(posedge clk or negedge RESB) begin
    if (!RESB) begin
      state     <= ST_POR;
      cnt       <= '0;
      PUONOUT   <= 1'b0;
      CPURSOUTB <= 1'b0;
      CE0       <= 1'b0;
      CLK30MHz  <= 1'b0;
      SRST_ACK  <= 1'b0;
      rst_cause <= 2'b00;
    end else begin
      CE0      <= 1'b0;
      CLK30MHz <= 1'b0;
      if (SRST_ACK && !SRST_REQ) begin
        SRST_ACK <= 1'b0;
      end
      case (state)
        ST_POR: begin
          if (cnt == PUON_LAST) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            PUONOUT <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (WDT_RST) begin
            state     <= ST_SRST;
            cnt       <= '0;
            rst_cause <= CAUSE_WDT;
          end else if (cnt == CPURS_LAST) begin
            state     <= ST_RUN;
            cnt       <= '0;
            CPURSOUTB <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (WDT_RST) begin
            state     <= ST_SRST;
            cnt       <= '0;
            CPURSOUTB <= 1'b0;
            rst_cause <= CAUSE_WDT;
          end else if (SRST_REQ && !SRST_ACK) begin
            state     <= ST_SRST;
            cnt       <= '0;
            CPURSOUTB <= 1'b0;
            rst_cause <= CAUSE_SW;
            SRST_ACK  <= 1'b1;
          end else begin
            // In RUN the phase counter doubles as the CE0 divider.
            CLK30MHz <= ~CLK30MHz;
            if (cnt == CE_LAST) begin
              cnt <= '0;
              CE0 <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_SRST: begin
          if (WDT_RST) begin
            cnt       <= '0;
            rst_cause <= CAUSE_WDT;
          end else if (cnt == SRST_LAST) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puon_rst_seq.sv
// Bench for puon_rst_seq: a default instance and a corner instance
// (PUON_CYCLES=1, CE_DIV=1) share stimulus and are scored against a timeline model.
module tb_puon_rst_seq;

  localparam logic [1:0] PH_POR  = 2'b00;
  localparam logic [1:0] PH_HOLD = 2'b01;
  localparam logic [1:0] PH_RUN  = 2'b10;
  localparam logic [1:0] PH_SRST = 2'b11;
  localparam int P_CPURS = 8;
  localparam int P_SRST  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resb, wdt, req;
  logic       ack0, puon0, cpursb0, ce0_0, clk30_0;
  logic [1:0] state0, cause0;
  logic       ack1, puon1, cpursb1, ce0_1, clk30_1;
  logic [1:0] state1, cause1;

  puon_rst_seq #(.PUON_CYCLES(16), .CPURS_CYCLES(8), .SRST_CYCLES(4), .CE_DIV(4), .CNT_W(8)) dut (
    .clk(clk), .RESB(resb), .WDT_RST(wdt), .SRST_REQ(req), .SRST_ACK(ack0),
    .PUONOUT(puon0), .CPURSOUTB(cpursb0), .CE0(ce0_0), .CLK30MHz(clk30_0),
    .seq_state(state0), .rst_cause(cause0)
  );

  puon_rst_seq #(.PUON_CYCLES(1), .CPURS_CYCLES(8), .SRST_CYCLES(4), .CE_DIV(1), .CNT_W(8)) dut_corner (
    .clk(clk), .RESB(resb), .WDT_RST(wdt), .SRST_REQ(req), .SRST_ACK(ack1),
    .PUONOUT(puon1), .CPURSOUTB(cpursb1), .CE0(ce0_1), .CLK30MHz(clk30_1),
    .seq_state(state1), .rst_cause(cause1)
  );

  // ---------------- reference model ----------------
  // Timeline view: n counts edges since RESB release; PUONOUT is n >= PUON,
  // an SRST pulse occupies [start, srst_end) and the CPU is released at cpu_rel.
  int         p_puon [2] = '{16, 1};
  int         p_cediv[2] = '{4, 1};
  int         m_n[2], m_srst_end[2], m_cpu_rel[2];
  logic [1:0] m_cause[2];
  logic       m_ack[2];

  function automatic logic [1:0] phase_at(int i, int n);
    if (n < p_puon[i])          return PH_POR;
    else if (n < m_srst_end[i]) return PH_SRST;
    else if (n < m_cpu_rel[i])  return PH_HOLD;
    else                        return PH_RUN;
  endfunction

  task automatic model_reset(input int i);
    m_n[i] = 0;
    m_srst_end[i] = 0;
    m_cpu_rel[i] = p_puon[i] + P_CPURS;
    m_cause[i] = 2'b00;
    m_ack[i] = 1'b0;
  endtask

  task automatic start_pulse(input int i, input int n, input logic [1:0] cause);
    m_srst_end[i] = n + P_SRST;
    m_cpu_rel[i] = m_srst_end[i] + P_CPURS;
    m_cause[i] = cause;
  endtask

  task automatic model_edge(input int i, input logic w, input logic r);
    logic [1:0] ph;
    logic       ack_old;
    int         n;
    ph = phase_at(i, m_n[i]);
    ack_old = m_ack[i];
    n = m_n[i] + 1;
    if (ack_old && !r) m_ack[i] = 1'b0;
    if (ph != PH_POR && w) begin
      start_pulse(i, n, 2'b10);
    end else if (ph == PH_RUN && r && !ack_old) begin
      start_pulse(i, n, 2'b01);
      m_ack[i] = 1'b1;
    end
    m_n[i] = n;
  endtask

  // Packed as {puon, cpursb, ce0, clk30, ack, state, cause}
  function automatic logic [8:0] expect_out(int i);
    logic [1:0] ph;
    int         k;
    logic       c30, ce;
    ph  = phase_at(i, m_n[i]);
    k   = m_n[i] - m_cpu_rel[i];
    c30 = (ph == PH_RUN) && (k % 2 == 1);
    ce  = (ph == PH_RUN) && (k > 0) && (k % p_cediv[i] == 0);
    return {m_n[i] >= p_puon[i], ph == PH_RUN, ce, c30, m_ack[i], ph, m_cause[i]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  initial begin
    logic [17:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {puon0, cpursb0, ce0_0, clk30_0, ack0, state0, cause0,
                 puon1, cpursb1, ce0_1, clk30_1, ack1, state1, cause1};
        for (int i = 0; i < 2; i++) begin
          logic [8:0] a, e;
          a = (i == 0) ? act_v[17:9] : act_v[8:0];
          e = (i == 0) ? exp_v[17:9] : exp_v[8:0];
          vectors++;
          if (a !== e) begin
            miscompares++;
            $display("FAIL outputs inst%0d t=%0t: got %b expected %b (puon,cpursb,ce0,clk30,ack,state,cause)",
                     i, $time, a, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (resb) for (int i = 0; i < 2; i++) model_edge(i, wdt, req);
  endtask

  task automatic apply(input logic r, input logic w, input logic q);
    resb = r;
    wdt  = w;
    req  = q;
    if (!r) for (int i = 0; i < 2; i++) model_reset(i);
    exp_q.push_back({expect_out(0), expect_out(1)});
    cyc++;
  endtask

  task automatic cycles(input int n, input logic r, input logic w, input logic q);
    for (int c = 0; c < n; c++) begin
      tick();
      apply(r, w, q);
    end
  endtask

  task automatic timeout_fail(input string what);
    vectors++;
    miscompares++;
    $display("FAIL timeout %s: got no event within budget, required one", what);
  endtask

  task automatic run_until(input logic [1:0] ph, input logic q);
    int k;
    k = 0;
    do begin
      tick();
      apply(1'b1, 1'b0, q);
      k++;
    end while (phase_at(0, m_n[0]) != ph && k < 200);
    if (k >= 200) timeout_fail("run_until");
  endtask

  // Hold WDT_RST and SRST_REQ high for as long as the main instance is in POR.
  task automatic por_with_noise();
    int k;
    k = 0;
    do begin
      tick();
      if (phase_at(0, m_n[0]) == PH_POR) apply(1'b1, 1'b1, 1'b1);
      else                               apply(1'b1, 1'b0, 1'b0);
      k++;
    end while (phase_at(0, m_n[0]) == PH_POR && k < 100);
    if (k >= 100) timeout_fail("por");
  endtask

  // Keep REQ high until the acknowledge arrives, then release it.
  task automatic request();
    int k;
    k = 0;
    while (!m_ack[0] && k < 200) begin
      tick();
      apply(1'b1, 1'b0, 1'b1);
      k++;
    end
    if (k >= 200) timeout_fail("srst_ack");
    cycles(1, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resb = 1'b0;
    wdt  = 1'b0;
    req  = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);

    cycles(3, 1'b0, 1'b0, 1'b0);
    por_with_noise();
    run_until(PH_RUN, 1'b0);
    cycles(10, 1'b1, 1'b0, 1'b0);

    request();
    run_until(PH_RUN, 1'b0);
    cycles(3, 1'b1, 1'b0, 1'b0);

    cycles(1, 1'b1, 1'b1, 1'b0);
    run_until(PH_RUN, 1'b0);
    cycles(3, 1'b1, 1'b0, 1'b0);

    // Watchdog, then a second watchdog two edges into the pulse.
    cycles(1, 1'b1, 1'b1, 1'b0);
    cycles(1, 1'b1, 1'b0, 1'b0);
    cycles(1, 1'b1, 1'b1, 1'b0);
    run_until(PH_RUN, 1'b0);
    cycles(3, 1'b1, 1'b0, 1'b0);

    // Collision: watchdog wins, the held request is acknowledged after recovery.
    cycles(1, 1'b1, 1'b1, 1'b1);
    request();
    run_until(PH_RUN, 1'b0);
    cycles(2, 1'b1, 1'b0, 1'b0);

    // Abort in the middle of HOLD, then a full restart.
    cycles(1, 1'b1, 1'b1, 1'b0);
    run_until(PH_HOLD, 1'b0);
    cycles(2, 1'b1, 1'b0, 1'b0);
    cycles(3, 1'b0, 1'b0, 1'b0);
    por_with_noise();
    run_until(PH_RUN, 1'b0);

    for (int c = 0; c < 300; c++) begin
      logic rb, w, q;
      tick();
      rb = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 29) == 0);
      if (m_ack[0])  q = ($urandom_range(0, 1) == 0) ? 1'b0 : req;
      else if (req)  q = 1'b1;
      else           q = ($urandom_range(0, 9) == 0);
      apply(rb, w, q);
    end

    cycles(2, 1'b0, 1'b0, 1'b0);

    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 10) begin
        @(posedge clk);
        k++;
      end
      if (exp_q.size() != 0) timeout_fail("drain");
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
